// File: rtl/bdt_pkg.sv
// Shared types for the block data transfer (LDM/STM) sequencer.
// FSM state encoding and default transfer stride.
package bdt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    BASE_RD,
    BASE_CAP,
    REG_RD,
    MEM_WR,
    MEM_RD,
    REG_WR,
    WB,
    DONE
  } bdt_state_e;

  localparam int BDT_STRIDE = 4;

endpackage

// File: rtl/bdt_lowest_bit.sv
// Priority encoder: index of the lowest set bit of vec, plus a valid flag.
// Used to pick the next register to transfer.
module bdt_lowest_bit #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/block_data_transfer.sv
// LDM/STM block data transfer sequencer with optional base write-back.
// Define BDT_LOAD_BASE_WINS_EN to keep a loaded base over write-back.
module block_data_transfer
  import bdt_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32,
  parameter int STRIDE = BDT_STRIDE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     pre,
  input  logic                     up,
  input  logic                     write,
  input  logic                     load,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [NREGS-1:0]         reg_list,
  output logic                     read_en,
  output logic [$clog2(NREGS)-1:0] read_reg,
  input  logic [ADDR_W-1:0]        read_value,
  output logic                     write_en,
  output logic [$clog2(NREGS)-1:0] write_reg,
  output logic [ADDR_W-1:0]        write_value,
  output logic                     write_restore_from_SPSR,
  output logic                     data_write_word_en,
  output logic [ADDR_W-1:0]        data_write_word_address,
  output logic [ADDR_W-1:0]        data_write_word_data,
  output logic                     data_read_word_en,
  output logic [ADDR_W-1:0]        data_read_word_address,
  input  logic [ADDR_W-1:0]        data_read_word_data,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  bdt_state_e state_q, state_n;

  logic [RW-1:0]     rn_q;
  logic              pre_q, up_q, write_q, load_q;
  logic [NREGS-1:0]  pend_q;
  logic [ADDR_W-1:0] addr_q, wb_q;

  logic [RW-1:0]     cur;
  logic              cur_valid;
  logic [NREGS-1:0]  pend_n;
  logic              last;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] span, start, wb_val;
  logic              wb_go;

  bdt_lowest_bit #(.N(NREGS), .W(RW)) u_lb (
    .vec   (pend_q),
    .idx   (cur),
    .valid (cur_valid)
  );

  assign pend_n = pend_q & (pend_q - 1'b1);
  assign last   = (pend_n == '0);

`ifdef BDT_LOAD_BASE_WINS_EN
  logic base_in_q;
  assign wb_go = write_q && !(load_q && base_in_q);
`else
  assign wb_go = write_q;
`endif

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (pend_q[i]) cnt = cnt + CW'(1);
    end
  end

  // read_value holds the base in BASE_CAP
  always_comb begin
    span   = ADDR_W'(STRIDE) * ADDR_W'(cnt);
    wb_val = up_q ? read_value + span
                  : read_value - span;
    unique case ({up_q, pre_q})
      2'b11:   start = read_value + ADDR_W'(STRIDE);
      2'b10:   start = read_value;
      2'b01:   start = read_value - span;
      default: start = read_value - span
                       + ADDR_W'(STRIDE);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rn_q    <= '0;
      pre_q   <= 1'b0;
      up_q    <= 1'b0;
      write_q <= 1'b0;
      load_q  <= 1'b0;
      pend_q  <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
`ifdef BDT_LOAD_BASE_WINS_EN
      base_in_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      unique case (state_q)
        IDLE: if (en) begin
          rn_q    <= rn;
          pre_q   <= pre;
          up_q    <= up;
          write_q <= write;
          load_q  <= load;
          pend_q  <= reg_list;
`ifdef BDT_LOAD_BASE_WINS_EN
          base_in_q <= reg_list[rn];
`endif
        end
        BASE_CAP: begin
          addr_q <= start;
          wb_q   <= wb_val;
        end
        MEM_WR, REG_WR: begin
          pend_q <= pend_n;
          addr_q <= addr_q + ADDR_W'(STRIDE);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n                 = state_q;
    read_en                 = 1'b0;
    read_reg                = '0;
    write_en                = 1'b0;
    write_reg               = '0;
    write_value             = '0;
    data_write_word_en      = 1'b0;
    data_write_word_address = '0;
    data_write_word_data    = '0;
    data_read_word_en       = 1'b0;
    data_read_word_address  = '0;
    done                    = 1'b0;
    unique case (state_q)
      IDLE: if (en) state_n = BASE_RD;
      BASE_RD: begin
        read_en  = 1'b1;
        read_reg = rn_q;
        state_n  = BASE_CAP;
      end
      BASE_CAP: begin
        if (!cur_valid) state_n = DONE;
        else if (load_q) state_n = MEM_RD;
        else state_n = REG_RD;
      end
      REG_RD: begin
        read_en  = 1'b1;
        read_reg = cur;
        state_n  = MEM_WR;
      end
      MEM_WR: begin
        data_write_word_en      = 1'b1;
        data_write_word_address = addr_q;
        data_write_word_data    = read_value;
        if (!last) state_n = REG_RD;
        else state_n = wb_go ? WB : DONE;
      end
      MEM_RD: begin
        data_read_word_en      = 1'b1;
        data_read_word_address = addr_q;
        state_n                = REG_WR;
      end
      REG_WR: begin
        write_en    = 1'b1;
        write_reg   = cur;
        write_value = data_read_word_data;
        if (!last) state_n = MEM_RD;
        else state_n = wb_go ? WB : DONE;
      end
      WB: begin
        write_en    = 1'b1;
        write_reg   = rn_q;
        write_value = wb_q;
        state_n     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy                    = (state_q != IDLE);
  assign write_restore_from_SPSR = 1'b0;

endmodule
